// File: rtl/rv32i_bus_arbiter_if.sv
// Bus bundle between the two CPU ports, the arbiter and the memory decoder.
// Handshake: a requester raises *_req_i and holds it, with stable address and data, until its
// one-cycle *_ack_o pulse; *_err_o and the read data are valid only in that ack cycle.
interface rv32i_bus_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int PORT_LEN = 32
);
    logic                ifetch_req_i;
    logic [XLEN-1:0]     ifetch_addr_i;
    logic                ifetch_ack_o;
    logic                ifetch_err_o;
    logic [PORT_LEN-1:0] ifetch_data_o;

    logic                data_req_i;
    logic                data_we_i;
    logic [XLEN-1:0]     data_addr_i;
    logic [PORT_LEN-1:0] data_wdata_i;
    logic                data_ack_o;
    logic                data_err_o;
    logic [PORT_LEN-1:0] data_rdata_o;

    logic [XLEN-1:0]     mem_addr_o;
    logic [PORT_LEN-1:0] mem_data_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic [PORT_LEN-1:0] mem_data_i;
    logic [3:0]          mem_region_i;

    logic                grant_o;
    logic                busy_o;

    modport slave (
        input  ifetch_req_i, ifetch_addr_i,
        output ifetch_ack_o, ifetch_err_o, ifetch_data_o,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
        output data_ack_o, data_err_o, data_rdata_o,
        output mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
        input  mem_data_i, mem_region_i,
        output grant_o, busy_o
    );

    modport master (
        output ifetch_req_i, ifetch_addr_i,
        input  ifetch_ack_o, ifetch_err_o, ifetch_data_o,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i,
        input  data_ack_o, data_err_o, data_rdata_o,
        input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
        output mem_data_i, mem_region_i,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/rv32i_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch and load/store ports,
// with a fixed number of extra access cycles for the slow ROM window.
module rv32i_bus_arbiter #(
    parameter int              XLEN      = 32,
    parameter int              PORT_LEN  = 32,
    parameter logic [XLEN-1:0] SLOW_B    = 32'h00020000,
    parameter logic [XLEN-1:0] SLOW_E    = 32'h00040000,
    parameter int unsigned     SLOW_WAIT = 2
) (
    input logic                 clk_i,
    input logic                 reset_ni,
    rv32i_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [3:0] WAIT_LD = 4'(SLOW_WAIT);

    state_e              state_q;
    logic                grant_q;
    logic                last_grant_q;
    logic [XLEN-1:0]     addr_q;
    logic                we_q;
    logic [PORT_LEN-1:0] wdata_q;
    logic [3:0]          cnt_q;
    logic                err_q;
    logic                read_q;
    logic                write_q;
    logic                busy_q;
    logic                f_ack_q;
    logic                d_ack_q;
    logic [PORT_LEN-1:0] f_data_q;
    logic [PORT_LEN-1:0] d_data_q;

    logic                win_d;
    logic [XLEN-1:0]     addr_d;
    logic                we_d;
    logic [PORT_LEN-1:0] wdata_d;
    logic                slow_d;

    // Data wins when it is alone, or on a tie when fetch was served last.
    always_comb begin
        win_d   = bus.data_req_i & (~bus.ifetch_req_i | ~last_grant_q);
        addr_d  = win_d ? bus.data_addr_i : bus.ifetch_addr_i;
        we_d    = win_d & bus.data_we_i;
        wdata_d = win_d ? bus.data_wdata_i : '0;
        slow_d  = (addr_d >= SLOW_B) && (addr_d < SLOW_E);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            f_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ifetch_req_i || bus.data_req_i) begin
                        state_q      <= ACCESS;
                        grant_q      <= win_d;
                        last_grant_q <= win_d;
                        addr_q       <= addr_d;
                        we_q         <= we_d;
                        wdata_q      <= wdata_d;
                        cnt_q        <= slow_d ? WAIT_LD : 4'd0;
                        read_q       <= ~we_d;
                        write_q      <= we_d;
                        busy_q       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        err_q   <= (bus.mem_region_i == 4'd0);
                        if (grant_q) begin
                            d_data_q <= we_q ? '0 : bus.mem_data_i;
                            d_ack_q  <= 1'b1;
                        end else begin
                            f_data_q <= bus.mem_data_i;
                            f_ack_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    f_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ifetch_ack_o  = f_ack_q;
    assign bus.ifetch_err_o  = f_ack_q & err_q;
    assign bus.ifetch_data_o = f_data_q;
    assign bus.data_ack_o    = d_ack_q;
    assign bus.data_err_o    = d_ack_q & err_q;
    assign bus.data_rdata_o  = d_data_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_data_o    = wdata_q;
    assign bus.mem_read_o    = read_q;
    assign bus.mem_write_o   = write_q;
    assign bus.grant_o       = grant_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Bench for rv32i_bus_arbiter: directed scenarios plus randomized two-port traffic,
// scoreboarded against a transaction-level timing and arbitration model.
module tb_rv32i_bus_arbiter;
  localparam logic [31:0] SLOW_B    = 32'h00020000;
  localparam logic [31:0] SLOW_E    = 32'h00040000;
  localparam int          SLOW_WAIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_bus_arbiter_if #(.XLEN(32), .PORT_LEN(32)) bus ();

  rv32i_bus_arbiter #(
    .XLEN(32), .PORT_LEN(32), .SLOW_B(SLOW_B), .SLOW_E(SLOW_E), .SLOW_WAIT(SLOW_WAIT)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus)
  );

  // memory decoder model
  logic        fix_en = 1'b0;
  logic [31:0] fix_data = '0;
  logic [3:0]  fix_region = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fix_en ? fix_data : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  function automatic logic [3:0] mem_reg(input logic [31:0] a);
    if (fix_en) return fix_region;
    return (a[31:20] == 12'd0) ? 4'(4'b0001 << a[19:18]) : 4'b0000;
  endfunction

  assign bus.mem_data_i   = mem_word(bus.mem_addr_o);
  assign bus.mem_region_i = mem_reg(bus.mem_addr_o);

  // scoreboard: {port, err, data, ack_cycle}
  logic [65:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  int          cyc = 0;
  int          free_cyc = 0;
  logic        last_data = 1'b1;
  logic        acc_valid = 1'b0;
  int          acc_start = 0;
  int          acc_end = 0;
  logic        acc_we = 1'b0;
  logic [31:0] acc_wd = '0;
  logic        exp_grant = 1'b0;
  logic [31:0] exp_maddr = '0;
  logic [31:0] hold_f = '0;
  logic [31:0] hold_d = '0;

  // Transaction-level model: a grant may happen once the bus has been free for a full
  // (3 + wait)-cycle slot; ties go to whichever port was not served last.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      free_cyc  = 0;
      last_data = 1'b1;
      acc_valid = 1'b0;
      exp_grant = 1'b0;
      exp_maddr = '0;
      hold_f    = '0;
      hold_d    = '0;
    end else begin
      cyc++;
      if (cyc >= free_cyc && (bus.ifetch_req_i || bus.data_req_i)) begin
        logic        win;
        logic [31:0] a;
        logic        we;
        int          w;
        logic [31:0] rd;
        win = (bus.ifetch_req_i && bus.data_req_i) ? ~last_data : bus.data_req_i;
        last_data = win;
        a  = win ? bus.data_addr_i : bus.ifetch_addr_i;
        we = win & bus.data_we_i;
        w  = (a >= SLOW_B && a < SLOW_E) ? SLOW_WAIT : 0;
        acc_valid = 1'b1;
        acc_start = cyc;
        acc_end   = cyc + w;
        acc_we    = we;
        acc_wd    = bus.data_wdata_i;
        exp_grant = win;
        exp_maddr = a;
        free_cyc  = cyc + w + 3;
        rd = we ? 32'd0 : mem_word(a);
        exp_q.push_back({win, (mem_reg(a) == 4'd0), rd, 32'(cyc + w + 1)});
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      logic in_acc;
      logic in_busy;
      check("dual_ack", 32'(bus.ifetch_ack_o & bus.data_ack_o), 32'd0);
      if (bus.ifetch_ack_o || bus.data_ack_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: fetch_ack=%b data_ack=%b with no pending transaction",
                   bus.ifetch_ack_o, bus.data_ack_o);
        end else begin
          logic [65:0] e;
          e = exp_q.pop_front();
          check("ack_port", 32'(bus.data_ack_o), 32'(e[65]));
          check("ack_cycle", 32'(cyc), e[31:0]);
          if (e[65]) begin
            check("data_err", 32'(bus.data_err_o), 32'(e[64]));
            check("data_rdata", bus.data_rdata_o, e[63:32]);
            hold_d = e[63:32];
          end else begin
            check("ifetch_err", 32'(bus.ifetch_err_o), 32'(e[64]));
            check("ifetch_data", bus.ifetch_data_o, e[63:32]);
            hold_f = e[63:32];
          end
        end
      end
      check("ifetch_data_hold", bus.ifetch_data_o, hold_f);
      check("data_rdata_hold", bus.data_rdata_o, hold_d);
      in_acc  = acc_valid && cyc >= acc_start && cyc <= acc_end;
      in_busy = acc_valid && cyc >= acc_start && cyc <= acc_end + 1;
      check("mem_read", 32'(bus.mem_read_o), 32'(in_acc && !acc_we));
      check("mem_write", 32'(bus.mem_write_o), 32'(in_acc && acc_we));
      check("busy", 32'(bus.busy_o), 32'(in_busy));
      check("grant", 32'(bus.grant_o), 32'(exp_grant));
      check("mem_addr", bus.mem_addr_o, exp_maddr);
      if (in_acc && acc_we) check("mem_wdata", bus.mem_data_o, acc_wd);
    end
  end

  // drivers
  task automatic fetch_txn(input logic [31:0] a, input int gap, input bit drop);
    bit done = 0;
    if (gap > 0) begin
      bus.ifetch_req_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.ifetch_req_i  = 1'b1;
    bus.ifetch_addr_i = a;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (drop && t == 1) bus.ifetch_req_i = 1'b0;
      if (bus.ifetch_ack_o) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fetch_timeout: no ack for addr %h", a);
    end
  endtask

  task automatic data_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input int gap, input bit drop);
    bit done = 0;
    if (gap > 0) begin
      bus.data_req_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = a;
    bus.data_we_i    = we;
    bus.data_wdata_i = wd;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (drop && t == 1) bus.data_req_i = 1'b0;
      if (bus.data_ack_o) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL data_timeout: no ack for addr %h", a);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges[4];
    edges[0] = 32'h0001FFFC;
    edges[1] = 32'h00020000;
    edges[2] = 32'h0003FFFC;
    edges[3] = 32'h00040000;
    case ($urandom_range(0, 3))
      0:       return SLOW_B | (32'($urandom_range(0, 32'h7FFF)) << 2);
      1:       return 32'($urandom_range(0, 32'h7FFF)) << 2;
      2:       return 32'h00100000 + (32'($urandom_range(0, 32'hFFFF)) << 2);
      default: return edges[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ifetch_req_i = 1'b0; bus.ifetch_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_addr_i = '0; bus.data_wdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_read", 32'(bus.mem_read_o), 32'd0);
    check("rst_write", 32'(bus.mem_write_o), 32'd0);
    check("rst_acks", 32'({bus.ifetch_ack_o, bus.data_ack_o}), 32'd0);
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_fdata", bus.ifetch_data_o, 32'd0);
    check("rst_ddata", bus.data_rdata_o, 32'd0);
    check("rst_maddr", bus.mem_addr_o, 32'd0);

    // both ports busy straight out of reset: fetch first, then strict alternation
    bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h00000040;
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h00001000;
    rst_n = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) fetch_txn(32'h00000040 + 32'(i * 4), 0, 0);
        bus.ifetch_req_i = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) data_txn(32'h00001000 + 32'(i * 4), 1'b0, '0, 0, 0);
        bus.data_req_i = 1'b0;
      end
    join
    repeat (3) @(negedge clk);

    fix_en = 1'b1; fix_data = 32'hDEADBEEF; fix_region = 4'b0001;
    fetch_txn(32'h00020010, 0, 0);
    bus.ifetch_req_i = 1'b0;
    fix_region = 4'b0010;
    data_txn(32'h00010004, 1'b1, 32'h12345678, 1, 0);
    bus.data_req_i = 1'b0;
    fix_data = 32'h0; fix_region = 4'b0000;
    data_txn(32'h00000100, 1'b0, '0, 1, 0);
    bus.data_req_i = 1'b0;
    fix_en = 1'b0;
    data_txn(32'h00020100, 1'b0, '0, 1, 1);
    bus.data_req_i = 1'b0;

    // reset during the second access cycle of a ROM fetch
    @(negedge clk);
    bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h00020040;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_read", 32'(bus.mem_read_o), 32'd0);
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_ack", 32'(bus.ifetch_ack_o), 32'd0);
    check("abort_grant", 32'(bus.grant_o), 32'd0);
    bus.ifetch_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch_txn(32'h00020080, 0, 0);
    bus.ifetch_req_i = 1'b0;
    repeat (2) @(negedge clk);

    // randomized two-port traffic
    fork
      begin
        for (int i = 0; i < 60; i++) fetch_txn(rand_addr(), $urandom_range(0, 3), 0);
        bus.ifetch_req_i = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++)
          data_txn(rand_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), 0);
        bus.data_req_i = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("pending_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv32i_bus_arbiter.md
RV32I_BUS_ARBITER -- requirements
Module: rv32i_bus_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- XLEN, 32, address width.
- PORT_LEN, 32, data width.
- SLOW_B, 32'h00020000, first address of the wait-stated (ROM) region.
- SLOW_E, 32'h00040000, first address past the wait-stated region.
- SLOW_WAIT, 2, extra ACCESS cycles for addresses in [SLOW_B, SLOW_E); legal range 0..15.

REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk_i  in  1  single clock; all state changes on rising edge.
- reset_ni  in  1  reset, asynchronous and active-low.
- ifetch_req_i  in  1  instruction-fetch read request; held until ack.
- ifetch_addr_i  in  XLEN  fetch address.
- ifetch_ack_o  out  1  one-cycle completion pulse, fetch port.
- ifetch_err_o  out  1  fetch targeted unmapped space; valid with ack.
- ifetch_data_o  out  PORT_LEN  fetched word; valid with ack.
- data_req_i  in  1  load/store request; held until ack.
- data_we_i  in  1  1 = store, 0 = load.
- data_addr_i  in  XLEN  load/store address.
- data_wdata_i  in  PORT_LEN  store data.
- data_ack_o  out  1  one-cycle completion pulse, data port.
- data_err_o  out  1  access targeted unmapped space; valid with ack.
- data_rdata_o  out  PORT_LEN  load data; valid with ack.
- mem_addr_o  out  XLEN  address to memory decoder.
- mem_data_o  out  PORT_LEN  write data to memory decoder.
- mem_read_o  out  1  read strobe.
- mem_write_o  out  1  write strobe.
- mem_data_i  in  PORT_LEN  read data from memory decoder, combinational from mem_addr_o.
- mem_region_i  in  4  one-hot region decode of mem_addr_o; 0 = unmapped.
- grant_o  out  1  owner of the current transaction: 0 = fetch, 1 = data.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-004 In IDLE with at least one request high at a clock edge, the FSM SHALL do all of the following, then enter ACCESS:
- Latch the winner's address, we (fetch forces we = 0) and wdata.
- Set grant_o to the winner.
- Load wait counter with SLOW_WAIT if the latched address is in [SLOW_B, SLOW_E), else 0.
REQ-005 If only one request is high, that requester SHALL win.
REQ-006 If both requests are high, the requester not granted last SHALL win (round-robin); last-grant resets to data, so the first tie goes to fetch.
REQ-007 During ACCESS, mem_addr_o and mem_data_o SHALL carry the latched values, and mem_read_o = !we and mem_write_o = we SHALL be held high for every ACCESS cycle.
REQ-008 In ACCESS with counter > 0, the counter SHALL decrement and the FSM SHALL stay in ACCESS.
REQ-009 In ACCESS with counter == 0, the block SHALL do all of the following, then enter DONE:
- Capture mem_data_i into the granted port's data register, or 0 for stores.
- Capture err = (mem_region_i == 0).
REQ-010 In DONE, the granted port's ack SHALL be high for exactly one cycle, with its err and data valid in that cycle; the FSM SHALL then return to IDLE.
REQ-011 A new grant SHALL NOT occur in DONE; the minimum request-to-request spacing is therefore 3 + wait cycles.
REQ-012 Transaction latency SHALL be: request sampled in IDLE at edge N -> ack high in cycle N+2+W, where W is the loaded wait count.
REQ-013 Deassertion of the owning request mid-transaction SHALL be ignored: the access completes and ack still pulses.
REQ-014 Request changes at the non-owning port SHALL have no effect until IDLE.
REQ-015 Outside ACCESS, mem_read_o and mem_write_o SHALL be 0 and mem_addr_o and mem_data_o SHALL hold their last value.
REQ-016 ack, err and strobes SHALL be decoded from registered state only; no combinational path from any *_req_i to any output.
REQ-017 Port data outputs SHALL hold their value until that port's next completion.

Reset
REQ-018 reset_ni low SHALL immediately set: state IDLE, all strobes/acks/errs 0, busy_o 0, grant_o 0, last-grant = data, counter 0, all data/address registers 0.
REQ-019 Reset asserted mid-ACCESS SHALL abort the transaction with no ack issued.
REQ-020 After release, the first rising edge SHALL sample requests normally.

Verification
REQ-021 Fetch 0x00020010 alone, SLOW_WAIT=2, mem_data_i=0xDEADBEEF -> 3 ACCESS cycles with mem_read_o=1; ifetch_ack_o pulses at N+4 with ifetch_data_o=0xDEADBEEF, err 0.
REQ-022 Store 0x00010004 data 0x12345678, region 4'b0010 -> one cycle mem_write_o=1, mem_data_o=0x12345678; data_ack_o at N+2; data_rdata_o=0.
REQ-023 Both requests high continuously from reset -> grants alternate fetch, data, fetch, data; no back-to-back acks on one port while the other waits.
REQ-024 Load 0x00000100 with mem_region_i=0 -> data_ack_o and data_err_o high together, data_rdata_o=0, FSM returns to IDLE.
REQ-025 reset_ni pulsed low during the second ACCESS cycle of a ROM fetch -> strobes drop asynchronously, no ifetch_ack_o; next fetch completes normally.
REQ-026 data_req_i dropped one cycle after grant -> access still completes and data_ack_o pulses once.
